// File: rtl/l1_ahb_mtx_pkg.sv
// Shared types and helpers for the L1 AHB bus matrix: HTRANS codes, output
// arbiter state encoding and the round-robin scan used by the picker.
package l1_ahb_mtx_pkg;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_OWNED  = 2'b01,
        ARB_LOCKED = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic [1:0] port;
        logic       valid;
    } arb_dphase_t;

    // Returns {found, index}. Scans last+1, last+2, ... modulo n; descending loop
    // so the nearest requester is the last one written.
    function automatic logic [2:0] rr_next(input logic [3:0] req, input logic [1:0] last,
                                           input int n);
        logic [2:0] r;
        int         idx;
        r = '0;
        for (int k = 4; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(last) + k) % n;
                if (req[idx[1:0]]) r = {1'b1, idx[1:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/l1_ahb_mtx_rr_pick.sv
// Combinational round-robin priority picker: first request after `last`.
module l1_ahb_mtx_rr_pick
    import l1_ahb_mtx_pkg::*;
#(
    parameter int NUM_IN = 3
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [1:0]        last,
    output logic [1:0]        win,
    output logic              found
);

    logic [3:0] req4;
    logic [2:0] pick;

    always_comb begin
        req4             = '0;
        req4[NUM_IN-1:0] = req;
    end

    assign pick  = rr_next(req4, last, NUM_IN);
    assign found = pick[2];
    assign win   = pick[1:0];

endmodule

// File: rtl/l1_ahb_mtx_out_arb.sv
// Output-stage arbiter for one matrix slave port: round-robin grant, held
// across bursts and locked sequences, with a registered data-phase owner.
module l1_ahb_mtx_out_arb
    import l1_ahb_mtx_pkg::*;
#(
    parameter int NUM_IN = 3
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [NUM_IN-1:0]     req_sel,
    input  logic [2*NUM_IN-1:0]   req_trans,
    input  logic [NUM_IN-1:0]     req_lock,
    input  logic                  HREADYM,
    output logic [NUM_IN-1:0]     active,
    output logic [1:0]            addr_in_port,
    output logic                  no_port,
    output logic [1:0]            data_in_port,
    output logic                  data_valid,
    output logic                  lock_out
);

    arb_state_e       state_q, state_d;
    logic [1:0]       owner_q, rr_last_q;
    arb_dphase_t      dph_q;

    // Inputs padded to four so a 2-bit owner index is always in range.
    logic [3:0]       sel4, lock4, req4;
    logic [3:0][1:0]  trans4;

    for (genvar g = 0; g < 4; g++) begin : g_pad
        if (g < NUM_IN) begin : g_in
            assign sel4[g]   = req_sel[g];
            assign lock4[g]  = req_lock[g];
            assign trans4[g] = req_trans[2*g +: 2];
        end else begin : g_nil
            assign sel4[g]   = 1'b0;
            assign lock4[g]  = 1'b0;
            assign trans4[g] = TRANS_IDLE;
        end
        assign req4[g] = sel4[g] & trans4[g][1];
    end

    logic [1:0] pick_idx, winner;
    logic       pick_found, hold, win_valid;

    l1_ahb_mtx_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
        .req   (req4[NUM_IN-1:0]),
        .last  (rr_last_q),
        .win   (pick_idx),
        .found (pick_found)
    );

    // Locked hold ignores trans so an IDLE inside the sequence keeps the port.
    assign hold = ((state_q == ARB_OWNED) && sel4[owner_q] &&
                   ((trans4[owner_q] == TRANS_BUSY) || (trans4[owner_q] == TRANS_SEQ))) ||
                  ((state_q == ARB_LOCKED) && sel4[owner_q] && lock4[owner_q]);

    assign winner    = hold ? owner_q : pick_idx;
    assign win_valid = hold | pick_found;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= ARB_IDLE;
        else if (HREADYM) state_q <= state_d;
    end

    always_comb begin
        state_d = ARB_IDLE;
        if (win_valid) state_d = lock4[winner] ? ARB_LOCKED : ARB_OWNED;
    end

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) active[i] = win_valid && (winner == i[1:0]);
        addr_in_port = winner;
        no_port      = !win_valid;
        lock_out     = (state_q == ARB_LOCKED) || (win_valid && lock4[winner]);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q   <= 2'd0;
            rr_last_q <= 2'(NUM_IN - 1);
            dph_q     <= '0;
        end else if (HREADYM) begin
            if (win_valid) owner_q <= winner;
            if (win_valid && !hold) rr_last_q <= winner;
            dph_q.port  <= winner;
            dph_q.valid <= win_valid && trans4[winner][1];
        end
    end

    assign data_in_port = dph_q.port;
    assign data_valid   = dph_q.valid;

endmodule
